// File: rtl/q2a03_joypad_if.sv
// q2a03_joypad_if - CPU-side bus bundle for the 2A03 joypad port block.
//   G_addr     : CPU bus address (master -> slave)
//   G_wr_data  : CPU write data (master -> slave)
//   G_rdwr     : 1 = read, 0 = write (master -> slave)
//   G_phy2     : CPU bus phase, transfer completes on its falling edge (master -> slave)
//   G_rd_data  : read data returned to the CPU (slave -> master)
//   G_sel      : high while G_addr selects the joypad block (slave -> master)
interface q2a03_joypad_if;
    logic [15:0] G_addr;
    logic [7:0]  G_wr_data;
    logic        G_rdwr;
    logic        G_phy2;
    logic [7:0]  G_rd_data;
    logic        G_sel;

    modport master (
        output G_addr, G_wr_data, G_rdwr, G_phy2,
        input  G_rd_data, G_sel
    );

    modport slave (
        input  G_addr, G_wr_data, G_rdwr, G_phy2,
        output G_rd_data, G_sel
    );
endinterface

// File: rtl/q2a03_joypad.sv
// q2a03_joypad - NES-style controller ports at $4016/$4017.
// A write to ADDR_P1 latches the strobe (OUT0). While the strobe is high both
// pad shift registers reload from the pad inputs every clock; once it is low,
// each completed read of a port shifts that port's register right, filling 1s.
// Ports:
//   G_clock     : system clock, all state on its rising edge
//   G_reset     : asynchronous active-low reset
//   bus         : CPU bus bundle (slave side), see q2a03_joypad_if
//   P_buttons1  : port-1 pad state, bit0 = A ... bit7 = Right, 1 = pressed
//   P_buttons2  : port-2 pad state, same bit order
//   P_strobe    : latched strobe
//   P_clk1      : one-clock pulse after each completed port-1 read
//   P_clk2      : one-clock pulse after each completed port-2 read
module q2a03_joypad #(
    parameter logic [15:0] ADDR_P1  = 16'h4016,
    parameter logic [15:0] ADDR_P2  = 16'h4017,
    parameter logic [2:0]  OPEN_BUS = 3'b010
) (
    input  logic                  G_clock,
    input  logic                  G_reset,
    q2a03_joypad_if.slave         bus,
    input  logic [7:0]            P_buttons1,
    input  logic [7:0]            P_buttons2,
    output logic                  P_strobe,
    output logic                  P_clk1,
    output logic                  P_clk2
);

    logic       phy2_q;
    logic       strobe_q, strobe_d;
    logic [7:0] sr1_q, sr1_d;
    logic [7:0] sr2_q, sr2_d;
    logic       clk1_q, clk1_d;
    logic       clk2_q, clk2_d;

    logic       fall;
    logic       hit1, hit2;
    logic       rd1, rd2, wr1;
    logic [7:0] rd_data;
    logic [6:0] unused_wr_bits;

    // Only OUT0 is implemented; the remaining write data bits have no function.
    assign unused_wr_bits = bus.G_wr_data[7:1];

    // Falling edge of phy2 is seen in the same clock the CPU completes the transfer.
    assign fall = phy2_q & ~bus.G_phy2;

    assign hit1 = (bus.G_addr == ADDR_P1);
    assign hit2 = (bus.G_addr == ADDR_P2);

    assign rd1 = fall &  bus.G_rdwr & hit1;
    assign rd2 = fall &  bus.G_rdwr & hit2;
    assign wr1 = fall & ~bus.G_rdwr & hit1;

    assign bus.G_sel = hit1 | hit2;

    // Read data shows the pre-edge register bit; the CPU samples on the shift edge.
    always_comb begin
        rd_data = '0;
        if (bus.G_rdwr) begin
            if (hit1) begin
                rd_data = {OPEN_BUS, 4'b0000, sr1_q[0]};
            end else if (hit2) begin
                rd_data = {OPEN_BUS, 4'b0000, sr2_q[0]};
            end
        end
    end

    assign bus.G_rd_data = rd_data;

    // Reload keys off the old strobe, so a 1->0 strobe write still freezes the
    // pads as of that same edge.
    always_comb begin
        strobe_d = strobe_q;
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        clk1_d   = rd1;
        clk2_d   = rd2;

        if (strobe_q) begin
            sr1_d = P_buttons1;
            sr2_d = P_buttons2;
        end else begin
            if (rd1) begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
            if (rd2) begin
                sr2_d = {1'b1, sr2_q[7:1]};
            end
        end

        if (wr1) begin
            strobe_d = bus.G_wr_data[0];
        end
    end

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            phy2_q   <= 1'b0;
            strobe_q <= 1'b0;
            sr1_q    <= '1;
            sr2_q    <= '1;
            clk1_q   <= 1'b0;
            clk2_q   <= 1'b0;
        end else begin
            phy2_q   <= bus.G_phy2;
            strobe_q <= strobe_d;
            sr1_q    <= sr1_d;
            sr2_q    <= sr2_d;
            clk1_q   <= clk1_d;
            clk2_q   <= clk2_d;
        end
    end

    assign P_strobe = strobe_q;
    assign P_clk1   = clk1_q;
    assign P_clk2   = clk2_q;

endmodule

// File: tb/tb_q2a03_joypad.sv
module tb_q2a03_joypad;

    logic       G_clock = 1'b0;
    logic       G_reset;
    logic [7:0] P_buttons1;
    logic [7:0] P_buttons2;
    logic       P_strobe;
    logic       P_clk1;
    logic       P_clk2;

    q2a03_joypad_if bus();

    q2a03_joypad #(
        .ADDR_P1 (16'h4016),
        .ADDR_P2 (16'h4017),
        .OPEN_BUS(3'b010)
    ) dut (
        .G_clock   (G_clock),
        .G_reset   (G_reset),
        .bus       (bus),
        .P_buttons1(P_buttons1),
        .P_buttons2(P_buttons2),
        .P_strobe  (P_strobe),
        .P_clk1    (P_clk1),
        .P_clk2    (P_clk2)
    );

    always #5 G_clock = ~G_clock;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each port: a frozen pad snapshot plus the number of reads made since the
    // strobe dropped. Read n returns snapshot bit n, or 1 once n >= 8.
    bit          m_strobe = 1'b0;
    bit          m_old;
    logic [7:0]  m_snap1  = 8'hFF;
    logic [7:0]  m_snap2  = 8'hFF;
    int unsigned m_cnt1   = 0;
    int unsigned m_cnt2   = 0;
    bit          m_clk1   = 1'b0;
    bit          m_clk2   = 1'b0;

    // Completed-transfer request, posted by the driver for the completing edge.
    bit          req      = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    bit          req_rd   = 1'b0;
    logic [7:0]  req_data = 8'h00;

    always @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            m_strobe = 1'b0;
            m_snap1  = 8'hFF;
            m_snap2  = 8'hFF;
            m_cnt1   = 0;
            m_cnt2   = 0;
            m_clk1   = 1'b0;
            m_clk2   = 1'b0;
        end else begin
            m_old  = m_strobe;
            m_clk1 = 1'b0;
            m_clk2 = 1'b0;
            if (req) begin
                if (req_rd && req_addr == 16'h4016) begin
                    m_clk1 = 1'b1;
                    if (!m_old) m_cnt1++;
                end
                if (req_rd && req_addr == 16'h4017) begin
                    m_clk2 = 1'b1;
                    if (!m_old) m_cnt2++;
                end
                if (!req_rd && req_addr == 16'h4016) m_strobe = req_data[0];
            end
            if (m_old) begin
                m_snap1 = P_buttons1;
                m_snap2 = P_buttons2;
                m_cnt1  = 0;
                m_cnt2  = 0;
            end
        end
    end

    function automatic logic [7:0] exp_rd();
        logic b;
        if (bus.G_rdwr !== 1'b1) return 8'h00;
        if (bus.G_addr == 16'h4016)      b = (m_cnt1 >= 8) ? 1'b1 : m_snap1[m_cnt1[2:0]];
        else if (bus.G_addr == 16'h4017) b = (m_cnt2 >= 8) ? 1'b1 : m_snap2[m_cnt2[2:0]];
        else return 8'h00;
        return {3'b010, 4'b0000, b};
    endfunction

    // Single compare process, every cycle, away from the active edge.
    always @(negedge G_clock) begin
        #2;
        chk("sel",     {7'b0, bus.G_sel}, {7'b0, (bus.G_addr == 16'h4016) || (bus.G_addr == 16'h4017)});
        chk("rd_data", bus.G_rd_data, exp_rd());
        chk("strobe",  {7'b0, P_strobe}, {7'b0, m_strobe});
        chk("clk1",    {7'b0, P_clk1}, {7'b0, m_clk1});
        chk("clk2",    {7'b0, P_clk2}, {7'b0, m_clk2});
    end

    // ---------------- driver ----------------
    task automatic xfer(input logic [15:0] a, input bit rd, input logic [7:0] d, output logic [7:0] got);
        @(negedge G_clock);
        bus.G_addr = a; bus.G_rdwr = rd; bus.G_wr_data = d; bus.G_phy2 = 1'b1;
        @(negedge G_clock);
        bus.G_phy2 = 1'b0;
        req = 1'b1; req_addr = a; req_rd = rd; req_data = d;
        #1 got = bus.G_rd_data;
        @(posedge G_clock);
        #1 req = 1'b0;
        @(negedge G_clock);
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] got;
        xfer(a, 1'b1, 8'h00, got);
        chk(nm, got, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] got;
        xfer(a, 1'b0, d, got);
    endtask

    logic [7:0] seq1 [9] = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41, 8'h41};
    logic [7:0] seq2 [9] = '{8'h40, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h40, 8'h40, 8'h41};

    initial begin
        G_reset       = 1'b0;
        P_buttons1    = 8'h00;
        P_buttons2    = 8'h00;
        bus.G_addr    = 16'h0000;
        bus.G_wr_data = 8'h00;
        bus.G_rdwr    = 1'b1;
        bus.G_phy2    = 1'b0;
        repeat (3) @(negedge G_clock);
        #1 chk("reset_strobe", {7'b0, P_strobe}, 8'h00);
        G_reset = 1'b1;

        // Read right after reset
        rd_chk("post_reset_read", 16'h4016, 8'h41);
        #1 chk("post_reset_sel", {7'b0, bus.G_sel}, 8'h01);
        chk("post_reset_clk1_pulse", {7'b0, P_clk1}, 8'h01);
        @(negedge G_clock);
        #1 chk("post_reset_clk1_single", {7'b0, P_clk1}, 8'h00);

        // Strobe and read out both ports, past the end of the register
        P_buttons1 = 8'b1010_0101;
        P_buttons2 = 8'h3C;
        wr(16'h4016, 8'hFF);
        #1 chk("strobe_set", {7'b0, P_strobe}, 8'h01);
        wr(16'h4016, 8'hFE);
        #1 chk("strobe_clear", {7'b0, P_strobe}, 8'h00);
        P_buttons1 = 8'h00;          // pads frozen; must not affect readout
        P_buttons2 = 8'hFF;
        for (int i = 0; i < 9; i++) rd_chk($sformatf("p1_seq%0d", i), 16'h4016, seq1[i]);
        for (int i = 0; i < 9; i++) rd_chk($sformatf("p2_seq%0d", i), 16'h4017, seq2[i]);

        // Strobe high: reads do not shift but still pulse
        P_buttons2 = 8'h01;
        wr(16'h4016, 8'h01);
        repeat (2) @(negedge G_clock);
        for (int i = 0; i < 3; i++) begin
            rd_chk($sformatf("strobe_hi_read%0d", i), 16'h4017, 8'h41);
            chk($sformatf("strobe_hi_clk2_%0d", i), {7'b0, P_clk2}, 8'h01);
        end
        wr(16'h4016, 8'h00);
        rd_chk("unshifted_bit0", 16'h4017, 8'h41);
        rd_chk("unshifted_bit1", 16'h4017, 8'h40);

        // Ignored writes
        wr(16'h4017, 8'h01);
        #1 chk("wr_4017_ignored", {7'b0, P_strobe}, 8'h00);
        wr(16'h4015, 8'h01);
        #1 chk("wr_4015_ignored", {7'b0, P_strobe}, 8'h00);
        chk("sel_4015", {7'b0, bus.G_sel}, 8'h00);
        rd_chk("rd_4015", 16'h4015, 8'h00);

        // Address changes with phy2 held high: no action
        P_buttons1 = 8'h02;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        @(negedge G_clock);
        bus.G_addr = 16'h0000; bus.G_rdwr = 1'b1; bus.G_phy2 = 1'b1;
        repeat (2) @(negedge G_clock);
        bus.G_addr = 16'h4016;
        repeat (2) @(negedge G_clock);
        bus.G_addr = 16'h4017;
        repeat (2) @(negedge G_clock);
        bus.G_addr = 16'h4016;
        repeat (2) @(negedge G_clock);
        #1 chk("phy2_high_no_clk1", {7'b0, P_clk1}, 8'h00);
        bus.G_addr = 16'h0000;
        repeat (2) @(negedge G_clock);
        bus.G_phy2 = 1'b0;
        @(negedge G_clock);
        rd_chk("phy2_high_no_shift0", 16'h4016, 8'h40);
        rd_chk("phy2_high_no_shift1", 16'h4016, 8'h41);

        // Reset after three reads, and reset mid-transfer
        P_buttons1 = 8'h00;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) rd_chk($sformatf("pre_reset_read%0d", i), 16'h4016, 8'h40);
        @(negedge G_clock);
        bus.G_addr = 16'h4016; bus.G_rdwr = 1'b1; bus.G_phy2 = 1'b1;
        @(negedge G_clock);
        #3 G_reset = 1'b0;
        @(negedge G_clock);
        bus.G_phy2 = 1'b0;
        @(negedge G_clock);
        G_reset = 1'b1;
        repeat (2) @(negedge G_clock);
        #1 chk("abort_no_clk1", {7'b0, P_clk1}, 8'h00);
        rd_chk("after_reset_read", 16'h4016, 8'h41);
        chk("after_reset_strobe", {7'b0, P_strobe}, 8'h00);

        repeat (3) @(negedge G_clock);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
